// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared widths, the zero register and the write-port request type.
package wb_ctrl_pkg;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-load bit per register and the id stall lookup.
module wb_scoreboard
  import wb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic [AW-1:0] set_addr,
  input  logic clr,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic stall,
  output logic [NREG-1:0] pending
);
  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else begin
      if (clr) pending[clr_addr] <= 1'b0;
      if (set && set_addr != ZERO_REG) pending[set_addr] <= 1'b1;
    end
  end
  always_comb begin
    stall = (rs1 != ZERO_REG && pending[rs1]) ||
            (rs2 != ZERO_REG && pending[rs2]) ||
            (rd != ZERO_REG && pending[rd]);
  end
endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: merges ex results and load returns into one registered regfile write port,
// with a one-entry load buffer, load scoreboard stall and write-port bypass.
module wb_ctrl
  import wb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ex_wen_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic ld_issue_i,
  input  logic [AW-1:0] ld_rd_i,
  input  logic ld_valid_i,
  output logic ld_ready_o,
  input  logic [AW-1:0] ld_waddr_i,
  input  logic [DW-1:0] ld_rdata_i,
  output logic reg_wen_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  input  logic [AW-1:0] id_rs1_i,
  input  logic [AW-1:0] id_rs2_i,
  input  logic [AW-1:0] id_rd_i,
  output logic stall_o,
  output logic rs1_byp_o,
  output logic rs2_byp_o,
  output logic [DW-1:0] byp_data_o
);
  logic buf_full;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic live, ld_acc;
  logic [AW-1:0] ld_acc_addr;
  logic [NREG-1:0] pending;
  wb_req_t req, wr;
  assign ld_ready_o = !buf_full;
  assign live = ld_valid_i && ld_ready_o;
  assign ld_acc = !ex_wen_i && (buf_full || live);
  assign ld_acc_addr = buf_full ? buf_addr : ld_waddr_i;
  always_comb begin
    req = ex_wen_i ? wb_req_t'{1'b1, ex_waddr_i, ex_wdata_i} :
          buf_full ? wb_req_t'{1'b1, buf_addr, buf_data} :
          live     ? wb_req_t'{1'b1, ld_waddr_i, ld_rdata_i} : '0;
  end
  // A live load that loses to ex parks in the buffer; the buffer drains on any ex-free cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      wr <= wb_req_t'{req.wen && req.waddr != ZERO_REG, req.waddr, req.wdata};
      if (ex_wen_i && live) begin
        buf_full <= 1'b1;
        buf_addr <= ld_waddr_i;
        buf_data <= ld_rdata_i;
      end else if (!ex_wen_i) buf_full <= 1'b0;
    end
  end
  wb_scoreboard u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .set(ld_issue_i),
    .set_addr(ld_rd_i),
    .clr(ld_acc),
    .clr_addr(ld_acc_addr),
    .rs1(id_rs1_i),
    .rs2(id_rs2_i),
    .rd(id_rd_i),
    .stall(stall_o),
    .pending(pending)
  );
  assign reg_wen_o = wr.wen;
  assign reg_waddr_o = wr.waddr;
  assign reg_wdata_o = wr.wdata;
  assign byp_data_o = wr.wdata;
  assign rs1_byp_o = wr.wen && id_rs1_i == wr.waddr && id_rs1_i != ZERO_REG;
  assign rs2_byp_o = wr.wen && id_rs2_i == wr.waddr && id_rs2_i != ZERO_REG;
  a_ex_pending: assert property (@(posedge clk) disable iff (!rst_n)
    ex_wen_i |-> !pending[ex_waddr_i]);
  a_issue_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_issue_i && ld_rd_i != ZERO_REG) |-> (!pending[ld_rd_i] || (ld_acc && ld_acc_addr == ld_rd_i)));
  a_ld_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    ld_valid_i |-> pending[ld_waddr_i]);
endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Write-back controller for the register file write port; the write-side counterpart of the register file's id read ports. It merges single-cycle ALU results from ex with multi-cycle load returns and drives one registered write port into regs. A pending-load scoreboard raises stall_o to id, and a write-port bypass lets id see the value being written in the current cycle.

Parameters:
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_wen_i  in  1  ex result valid this cycle (no backpressure)
ex_waddr_i  in  AW  ex destination register
ex_wdata_i  in  DW  ex result
ld_issue_i  in  1  load issued this cycle
ld_rd_i  in  AW  destination of the issued load
ld_valid_i  in  1  load data returning
ld_ready_o  out  1  wb_ctrl can accept load data
ld_waddr_i  in  AW  returning load destination
ld_rdata_i  in  DW  returning load data
reg_wen_o  out  1  write enable to regs
reg_waddr_o  out  AW  write address to regs
reg_wdata_o  out  DW  write data to regs
id_rs1_i  in  AW  id source 1
id_rs2_i  in  AW  id source 2
id_rd_i  in  AW  id destination
stall_o  out  1  id must hold its instruction
rs1_byp_o  out  1  rs1 matches the active write
rs2_byp_o  out  1  rs2 matches the active write
byp_data_o  out  DW  equals reg_wdata_o

Behaviour:
- Reset (rst_n low, async): reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, load buffer empty, scoreboard all 0. ld_ready_o=1 after reset is released.
- Write port is registered: a source accepted in cycle N appears on reg_* in cycle N+1. regs commits it at the next posedge.
- Any write to address 0 is dropped: reg_wen_o stays 0, and the scoreboard bit for x0 is never set.
- Arbitration per cycle, highest priority first:
  1. ex_wen_i
  2. buffered load
  3. live ld_valid_i&&ld_ready_o
- ex is never stalled.
- Load buffer holds 1 entry. A load handshake (ld_valid_i&&ld_ready_o) that loses arbitration is captured in the buffer.
- ld_ready_o = !buffer_full. It is combinational from state only and does not depend on ld_valid_i.
- If the buffer is full and ex_wen_i=0, the buffer drains. A live load arriving that cycle is refused because ld_ready_o=0.
- Scoreboard is a NREG-bit pending vector:
  - set bit[ld_rd_i] on ld_issue_i (rd!=0);
  - clear bit[addr] when a load result is accepted onto the write port;
  - if set and clear hit the same bit in the same cycle, set wins.
- stall_o = pending[id_rs1_i] | pending[id_rs2_i] | pending[id_rd_i], ignoring any address equal to 0. It is combinational and prevents RAW and WAW hazards against in-flight loads.
- Bypass: rsN_byp_o = reg_wen_o && (id_rsN_i==reg_waddr_o) && id_rsN_i!=0.
- Protocol violations are flagged by assertions, not handled:
  - ex_wen_i to an address whose scoreboard bit is set;
  - ld_issue_i to an address that is already pending;
  - ld_valid_i for an address that is not pending.
- Reset asserted mid-operation discards the buffer and the pending bits. Any load data returning after reset is ignored by assertion.

Decomposition:
- Shared package (core-wide, e.g. core_defines): AW, DW, NREG, ZERO_REG=0, and a wb_req struct {wen, waddr, wdata}.
- One sub-module is natural: wb_scoreboard (pending vector, set/clear, stall lookup).
- Arbitration, the load buffer and the write-port register stay in wb_ctrl.

Test Plan:
- ex_wen_i=1, waddr=5, wdata=0xDEADBEEF -> next cycle reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF; with id_rs1_i=5 in that cycle, rs1_byp_o=1.
- ex_wen_i=1, waddr=0, wdata=0x1234 -> reg_wen_o stays 0 and no bypass asserted.
- ld_issue_i rd=7, then id_rs2_i=7 -> stall_o=1 until ld_valid_i (waddr=7, data=0x55) is accepted; stall_o=0 in the cycle after acceptance, and reg_wdata_o=0x55 one cycle after acceptance.
- ex_wen_i (rd=3, 0xA) and ld_valid_i (rd=9, 0xB) in the same cycle -> rd 3 written in cycle N+1, rd 9 in N+2. ld_ready_o=0 during N+1; a second ld_valid_i in N+1 is not accepted.
- Continuous ex_wen_i for 4 cycles while a load is buffered -> ld_ready_o=0 throughout; the buffered load is written on the first cycle with no ex write, and no data is lost or duplicated.
- Mid-flight reset: ld_issue_i rd=10 and buffer full, then rst_n=0 -> outputs 0 immediately (async); after release, stall_o=0 for id_rs1_i=10 and ld_ready_o=1.
